// File: rtl/krnl_local_mem_pkg.sv
// krnl_local_mem_pkg: shared types, constants and helpers for the URAM local-memory wrapper.
package krnl_local_mem_pkg;

    typedef enum logic [1:0] {S_RST, S_IDLE, S_CLEAR} state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic logic [7:0] be_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic be);
        return be ? new_b : old_b;
    endfunction

    function automatic bit params_ok(input int dw, input int depth, input int aw, input int lat, input int rdw);
        return dw > 0 && dw % 8 == 0 && lat >= 1 && lat <= 4 && depth > 0 && aw > 0 && aw < 31
            && (1 << aw) >= depth && (rdw == RDW_READ_FIRST || rdw == RDW_WRITE_FIRST);
    endfunction

endpackage

// File: rtl/krnl_local_mem_rd_pipe.sv
// krnl_local_mem_rd_pipe: ce-gated data+valid delay line; data stages load only on valid so they hold the last word.
module krnl_local_mem_rd_pipe #(
    parameter int WIDTH  = 256,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (STAGES == 0) begin : g_bypass
        assign o_valid = i_valid;
        assign o_data  = i_data;
    end else begin : g_stages
        logic [STAGES-1:0] r_valid;
        logic [STAGES:0]   w_vin;
        logic [WIDTH-1:0]  r_data [STAGES];
        logic [WIDTH-1:0]  w_din  [STAGES+1];
        assign w_vin    = {r_valid, i_valid};
        assign w_din[0] = i_data;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_valid <= '0;
            else if (i_ce)
                r_valid <= w_vin[STAGES-1:0];
        end
        for (genvar s = 0; s < STAGES; s++) begin : g_st
            assign w_din[s+1] = r_data[s];
            always_ff @(posedge i_clk) begin
                if (i_ce && w_vin[s])
                    r_data[s] <= w_din[s];
            end
        end
        assign o_valid = r_valid[STAGES-1];
        assign o_data  = r_data[STAGES-1];
    end

endmodule

// File: rtl/krnl_local_mem_uram_1r1w_pipe.sv
// krnl_local_mem_uram_1r1w_pipe: 1R1W byte-enable URAM buffer with pipelined reads,
// collision handling and a zero-fill clear sequencer.
module krnl_local_mem_uram_1r1w_pipe
    import krnl_local_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int DEPTH          = 2048,
    parameter int ADDR_WIDTH     = 11,
    parameter int RD_LATENCY     = 2,
    parameter int RD_DURING_WR   = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear_req,
    output logic                    o_busy,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic                    i_rd_en,
    input  logic                    i_rd_ce,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_valid
);

    localparam int BW = DATA_WIDTH / 8;

    if (!params_ok(DATA_WIDTH, DEPTH, ADDR_WIDTH, RD_LATENCY, RD_DURING_WR)) begin : g_bad_params
        $error("krnl_local_mem_uram_1r1w_pipe: illegal parameter combination");
    end

    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic                    r_busy;
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic                    r_seen;
    logic                    w_wr_acc, w_rd_acc, w_rd_in, w_coll, w_clr_last, w_out_valid;
    logic [DATA_WIDTH-1:0]   w_old, w_merged, w_rd_word, w_out_data;

    assign w_wr_acc   = i_wr_en && !r_busy && 32'(i_wr_addr) < DEPTH;
    assign w_rd_acc   = i_rd_en && i_rd_ce && !r_busy;
    assign w_rd_in    = 32'(i_rd_addr) < DEPTH;
    assign w_coll     = w_wr_acc && i_wr_addr == i_rd_addr;
    assign w_clr_last = r_clr_cnt == ADDR_WIDTH'(DEPTH - 1);
    assign w_old      = r_mem[i_rd_addr];

    // Write-first is a stage-1 bypass so it does not depend on the URAM collision mode.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < BW; i++)
            w_merged[i*8+:8] = be_merge(w_old[i*8+:8], i_wr_data[i*8+:8], i_wr_be[i]);
    end

    assign w_rd_word = !w_rd_in ? '0 : (RD_DURING_WR == RDW_WRITE_FIRST && w_coll) ? w_merged : w_old;

    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR)
            r_mem[r_clr_cnt] <= '0;
        else if (w_wr_acc)
            for (int i = 0; i < BW; i++)
                if (i_wr_be[i])
                    r_mem[i_wr_addr][i*8+:8] <= i_wr_data[i*8+:8];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_RST;
            r_busy    <= CLEAR_ON_RESET != 0;
            r_clr_cnt <= '0;
        end else begin
            unique case (r_state)
                S_RST: begin
                    r_state <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_IDLE;
                    r_busy  <= CLEAR_ON_RESET != 0;
                end
                S_IDLE: begin
                    if (i_clear_req) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
                    if (w_clr_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_RST;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_s1_valid <= 1'b0;
        else if (i_rd_ce)
            r_s1_valid <= w_rd_acc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_ce && w_rd_acc)
            r_s1_data <= w_rd_word;
    end

    krnl_local_mem_rd_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ce    (i_rd_ce),
        .i_valid (r_s1_valid),
        .i_data  (r_s1_data),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    // Data registers carry no reset; rd_data reads zero until the first word emerges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_seen <= 1'b0;
        else if (w_out_valid)
            r_seen <= 1'b1;
    end

    assign o_busy     = r_busy;
    assign o_rd_valid = w_out_valid;
    assign o_rd_data  = (r_seen || w_out_valid) ? w_out_data : '0;

endmodule

// File: doc/krnl_local_mem_uram_1r1w_pipe.md
Name: krnl_local_mem_uram_1r1w_pipe

Overview:
Parametrised successor to the single-port URAM local-buffer wrapper used by the partialKnn kernels. It provides one write port and one read port, byte-write enables, and a configurable registered read latency. It also resolves same-address read/write collisions and runs a built-in clear sequencer that zero-fills the array after reset or on request. Kernel local scratch arrays (distance/label buffers) instantiate it directly; the array is inferred behaviourally with URAM style.

Parameters:
DATA_WIDTH, 256, word width in bits; must be a multiple of 8.
DEPTH, 2048, number of words; need not be a power of two.
ADDR_WIDTH, 11, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
RD_LATENCY, 2, read latency in accepted-pipeline cycles; legal range 1..4.
RD_DURING_WR, 0, collision mode: 0 = read-first (old data), 1 = write-first (new merged data).
CLEAR_ON_RESET, 1, 1 = zero-fill the array automatically after reset deassertion.

Ports:
clk  in  1  clock, all logic rising-edge.
reset  in  1  asynchronous, active-low reset.
clear_req  in  1  single-cycle request to zero-fill the array.
busy  out  1  high while clearing; user reads and writes are ignored.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_WIDTH  write address.
wr_be  in  DATA_WIDTH/8  byte write enables.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read request.
rd_ce  in  1  read pipeline advance; 0 freezes all read stages.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data is valid this cycle.

Behaviour:
- Reset (reset=0, async): FSM goes to S_RST; busy=CLEAR_ON_RESET; rd_valid=0; rd_data=0; clear counter=0; all pipeline valid bits cleared. Memory contents are not reset.
- FSM states:
  - S_RST: one cycle after deassertion, then S_CLEAR if CLEAR_ON_RESET, else S_IDLE.
  - S_IDLE: busy=0. clear_req=1 moves to S_CLEAR on the next cycle.
  - S_CLEAR: busy=1. Each cycle writes all-zero to address clr_cnt, then clr_cnt++. When clr_cnt==DEPTH-1, the FSM writes that address and goes to S_IDLE. A clear takes exactly DEPTH cycles. clear_req during S_CLEAR is ignored (no restart).
- Reset asserted mid-clear aborts the clear. After deassertion the clear restarts from address 0 if CLEAR_ON_RESET; otherwise contents are undefined.
- Write: accepted when wr_en & ~busy. Only bytes with wr_be[i]=1 are updated. wr_be=0 is a no-op. Writes do not depend on rd_ce.
- Read: accepted when rd_en & rd_ce & ~busy. The array read plus register stages total RD_LATENCY stages. All stages advance only when rd_ce=1. rd_valid rises RD_LATENCY rd_ce-high cycles after acceptance. When rd_ce=0, rd_data and rd_valid hold their values. Back-to-back reads are sustained at 1 per cycle.
- Idle read output: rd_data holds the last valid value; rd_valid=0 when no read is in that stage.
- Out of range (addr >= DEPTH): the write is dropped; the read returns all-zero with rd_valid=1.
- Collision (accepted read and write to the same in-range address, same cycle):
  - RD_DURING_WR=0: returns pre-write word.
  - RD_DURING_WR=1: returns the old word with wr_be bytes replaced by wr_data. This is implemented via a bypass mux in stage 1, not by relying on URAM mode.
- Reads accepted before busy rises still complete and drain normally.

Decomposition:
- Package krnl_local_mem_pkg holds:
  - FSM state enum {S_RST, S_IDLE, S_CLEAR};
  - collision-mode constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - function for byte-enable merge (old, new, be);
  - elaboration-time parameter checks (DATA_WIDTH%8, RD_LATENCY range, DEPTH vs ADDR_WIDTH).
- Sub-module krnl_local_mem_rd_pipe: a ce-gated data+valid delay line of RD_LATENCY-1 register stages with async active-low reset on the valid bits only.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=2048 -> busy=1 for exactly 2048 cycles after the S_RST cycle; then reading addr 0, 1023 and 2047 returns 0 with rd_valid 2 cycles after rd_en.
- Write addr 5 = 0xA5..A5 (all be), then rd_en addr 5 on the next cycle with rd_ce=1 -> rd_valid high 2 cycles later, rd_data=0xA5..A5. Then back-to-back reads of addrs 5, 6, 5 -> 3 consecutive valid cycles with the correct data.
- Write 0xFF..FF to addr 9, then write 0x00..00 with wr_be=0x0000_0001 -> read returns 0xFF..FF00.
- Collision: addr 3 holds 0x11..11; same cycle write 0x22..22 (all be) + read addr 3 -> with RD_DURING_WR=0, rd_data=0x11..11; with RD_DURING_WR=1, rd_data=0x22..22.
- rd_ce=0 for 3 cycles right after the read of addr 5 is accepted -> rd_valid delayed by 3 cycles; data is unchanged and not duplicated.
- clear_req in IDLE, reset pulsed low at clear cycle 100 -> after deassertion busy=1 for a full 2048 cycles again. Separately, with DEPTH=2000, ADDR_WIDTH=11: write to addr 2040 is dropped, and a read of addr 2040 returns 0 with rd_valid=1.
